// File: rtl/mcdf_fmt_pkg.sv
// rtl/mcdf_fmt_pkg.sv - shared widths, FSM encodings and length decode for the MCDF formatter
package mcdf_fmt_pkg;

  localparam int DATA_WIDE       = 32;
  localparam int CACHE_PTR_WIDE  = 6;
  localparam int FMT_CACHE_DEPTH = 64;

  typedef enum logic [5:0] {
    ST_CHECK      = 6'b000001,
    ST_HAND_SHAKE = 6'b000010,
    ST_SENT_START = 6'b000100,
    ST_DATA_SENT  = 6'b001000,
    ST_SENT_END   = 6'b010000,
    ST_FLAG_CLR   = 6'b100000
  } fmt_state_e;

  function automatic logic [CACHE_PTR_WIDE-1:0] decode_len(input logic [2:0] code);
    logic [CACHE_PTR_WIDE-1:0] len;
    case (code)
      3'd0:    len = 6'd4;
      3'd1:    len = 6'd8;
      3'd2:    len = 6'd16;
      default: len = 6'd32;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fmt_cache.sv
// rtl/fmt_cache.sv - packet word cache: one registered write port, one combinational read port
module fmt_cache
  import mcdf_fmt_pkg::*;
(
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [CACHE_PTR_WIDE-1:0] i_waddr,
  input  logic [DATA_WIDE-1:0]      i_wdata,
  input  logic [CACHE_PTR_WIDE-1:0] i_raddr,
  output logic [DATA_WIDE-1:0]      o_rdata
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [DATA_WIDE-1:0] r_mem [FMT_CACHE_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mcdf_formatter.sv
// rtl/mcdf_formatter.sv - collects one uplink packet into the cache, then frames it downstream
module mcdf_formatter
  import mcdf_fmt_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                fmt_uplink_chid,
  input  logic [2:0]                fmt_fifo0_length,
  input  logic [2:0]                fmt_fifo1_length,
  input  logic [2:0]                fmt_fifo2_length,
  input  logic                      fmt_grant,
  input  logic                      fmt_uplink_valid,
  input  logic [DATA_WIDE-1:0]      fmt_data_in,
  output logic                      fmt_uplink_ready,
  output logic [1:0]                fmt_chid,
  output logic [CACHE_PTR_WIDE-1:0] fmt_length,
  output logic                      fmt_req,
  output logic                      fmt_start,
  output logic                      fmt_end,
  output logic [DATA_WIDE-1:0]      fmt_data
);

  fmt_state_e                r_state;
  logic [CACHE_PTR_WIDE-1:0] r_wptr;
  logic [CACHE_PTR_WIDE-1:0] r_rptr;
  logic [CACHE_PTR_WIDE-1:0] r_cnt;
  logic [CACHE_PTR_WIDE-1:0] r_len;
  logic [1:0]                r_chid;
  logic                      r_open;
  logic                      r_ready;
  logic                      r_req;
  logic                      r_start;
  logic                      r_end;
  logic [1:0]                r_fmt_chid;
  logic [CACHE_PTR_WIDE-1:0] r_fmt_len;
  logic [DATA_WIDE-1:0]      r_data;

  logic                      w_accept;
  logic [2:0]                w_len_code;
  logic [DATA_WIDE-1:0]      w_rd_data;

  // Once a packet is open the uplink channel id no longer gates acceptance.
  assign w_accept = fmt_uplink_valid & r_ready & ((fmt_uplink_chid != 2'd0) | r_open);

  always_comb begin
    w_len_code = 3'd0;
    case (fmt_uplink_chid)
      2'd1:    w_len_code = fmt_fifo0_length;
      2'd2:    w_len_code = fmt_fifo1_length;
      2'd3:    w_len_code = fmt_fifo2_length;
      default: w_len_code = 3'd0;
    endcase
  end

  fmt_cache u_cache (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wptr),
    .i_wdata (fmt_data_in),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_data)
  );

  // r_rptr always addresses the word to be driven on the following cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= ST_CHECK;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_chid     <= '0;
      r_open     <= 1'b0;
      r_ready    <= 1'b0;
      r_req      <= 1'b0;
      r_start    <= 1'b0;
      r_end      <= 1'b0;
      r_fmt_chid <= '0;
      r_fmt_len  <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        ST_CHECK: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_wptr <= r_wptr + 6'd1;
            if (!r_open) begin
              r_open <= 1'b1;
              r_chid <= fmt_uplink_chid;
              r_len  <= decode_len(w_len_code);
              r_cnt  <= 6'd1;
            end else begin
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt + 6'd1 == r_len) begin
                r_state    <= ST_HAND_SHAKE;
                r_ready    <= 1'b0;
                r_req      <= 1'b1;
                r_fmt_chid <= r_chid;
                r_fmt_len  <= r_len;
              end
            end
          end
        end
        ST_HAND_SHAKE: begin
          if (fmt_grant) begin
            r_state <= ST_SENT_START;
            r_req   <= 1'b0;
            r_start <= 1'b1;
            r_data  <= w_rd_data;
            r_rptr  <= r_rptr + 6'd1;
          end
        end
        ST_SENT_START: begin
          r_state <= ST_DATA_SENT;
          r_start <= 1'b0;
          r_data  <= w_rd_data;
          r_rptr  <= r_rptr + 6'd1;
        end
        ST_DATA_SENT: begin
          r_data <= w_rd_data;
          r_rptr <= r_rptr + 6'd1;
          if (r_rptr == r_len - 6'd1) begin
            r_state <= ST_SENT_END;
            r_end   <= 1'b1;
          end
        end
        ST_SENT_END: begin
          r_state    <= ST_FLAG_CLR;
          r_end      <= 1'b0;
          r_data     <= '0;
          r_fmt_chid <= '0;
          r_fmt_len  <= '0;
          r_wptr     <= '0;
          r_rptr     <= '0;
          r_cnt      <= '0;
          r_len      <= '0;
          r_chid     <= '0;
          r_open     <= 1'b0;
        end
        ST_FLAG_CLR: begin
          r_state <= ST_CHECK;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_CHECK;
        end
      endcase
    end
  end

  assign fmt_uplink_ready = r_ready;
  assign fmt_req          = r_req;
  assign fmt_start        = r_start;
  assign fmt_end          = r_end;
  assign fmt_chid         = r_fmt_chid;
  assign fmt_length       = r_fmt_len;
  assign fmt_data         = r_data;

endmodule

// File: tb/tb_mcdf_formatter.sv
// tb/tb_mcdf_formatter.sv - directed table-driven bench for mcdf_formatter
module tb_mcdf_formatter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  fmt_uplink_chid;
  logic [2:0]  fmt_fifo0_length;
  logic [2:0]  fmt_fifo1_length;
  logic [2:0]  fmt_fifo2_length;
  logic        fmt_grant;
  logic        fmt_uplink_valid;
  logic [31:0] fmt_data_in;
  logic        fmt_uplink_ready;
  logic [1:0]  fmt_chid;
  logic [5:0]  fmt_length;
  logic        fmt_req;
  logic        fmt_start;
  logic        fmt_end;
  logic [31:0] fmt_data;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [1:0]  chid;
    logic [2:0]  lcode;
    logic [5:0]  exp_len;
    int          gwait;
    logic [31:0] base;
  } vec_t;

  vec_t vecs[6];

  mcdf_formatter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fmt_uplink_chid  (fmt_uplink_chid),
    .fmt_fifo0_length (fmt_fifo0_length),
    .fmt_fifo1_length (fmt_fifo1_length),
    .fmt_fifo2_length (fmt_fifo2_length),
    .fmt_grant        (fmt_grant),
    .fmt_uplink_valid (fmt_uplink_valid),
    .fmt_data_in      (fmt_data_in),
    .fmt_uplink_ready (fmt_uplink_ready),
    .fmt_chid         (fmt_chid),
    .fmt_length       (fmt_length),
    .fmt_req          (fmt_req),
    .fmt_start        (fmt_start),
    .fmt_end          (fmt_end),
    .fmt_data         (fmt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  32'(fmt_uplink_ready), 32'd0);
    check({tag, "_req"},    32'(fmt_req),          32'd0);
    check({tag, "_start"},  32'(fmt_start),        32'd0);
    check({tag, "_end"},    32'(fmt_end),          32'd0);
    check({tag, "_chid"},   32'(fmt_chid),         32'd0);
    check({tag, "_length"}, 32'(fmt_length),       32'd0);
    check({tag, "_data"},   fmt_data,              32'd0);
  endtask

  // Feeds one packet, optionally switching uplink chid mid-packet, then checks the framed output.
  task automatic run_packet(input logic [1:0] ch, input logic [2:0] lc, input logic [5:0] exp_len,
                            input int gwait, input logic [31:0] base,
                            input logic [1:0] ch_alt, input int sw_at);
    logic [2:0] other;
    int         len;
    int         stall_bad;
    len       = int'(exp_len);
    stall_bad = 0;
    other     = (lc >= 3'd3) ? 3'd2 : 3'd7;
    fmt_fifo0_length = (ch == 2'd1) ? lc : other;
    fmt_fifo1_length = (ch == 2'd2) ? lc : other;
    fmt_fifo2_length = (ch == 2'd3) ? lc : other;
    check("pkt_ready_idle", 32'(fmt_uplink_ready), 32'd1);
    for (int i = 0; i < len; i++) begin
      fmt_uplink_chid  = (i >= sw_at) ? ch_alt : ch;
      fmt_data_in      = base + 32'(i);
      fmt_uplink_valid = 1'b1;
      tick();
    end
    fmt_uplink_valid = 1'b0;
    fmt_uplink_chid  = 2'd0;
    check("hs_ready",  32'(fmt_uplink_ready), 32'd0);
    check("hs_req",    32'(fmt_req),          32'd1);
    check("hs_chid",   32'(fmt_chid),         32'(ch));
    check("hs_length", 32'(fmt_length),       32'(exp_len));
    check("hs_start",  32'(fmt_start),        32'd0);
    for (int g = 0; g < gwait; g++) begin
      tick();
      if (fmt_req !== 1'b1 || fmt_uplink_ready !== 1'b0 || fmt_start !== 1'b0) stall_bad++;
    end
    check("hs_hold_cycles_bad", 32'(stall_bad), 32'd0);
    fmt_grant = 1'b1;
    tick();
    fmt_grant = 1'b0;
    check("st_start",  32'(fmt_start),  32'd1);
    check("st_req",    32'(fmt_req),    32'd0);
    check("st_end",    32'(fmt_end),    32'd0);
    check("st_data",   fmt_data,        base);
    check("st_chid",   32'(fmt_chid),   32'(ch));
    check("st_length", 32'(fmt_length), 32'(exp_len));
    for (int k = 1; k < len; k++) begin
      tick();
      check("tx_data",  fmt_data,          base + 32'(k));
      check("tx_start", 32'(fmt_start),    32'd0);
      check("tx_end",   32'(fmt_end),      (k == len - 1) ? 32'd1 : 32'd0);
      check("tx_chid",  32'(fmt_chid),     32'(ch));
    end
    tick();
    check_all_zero("clr");
    tick();
    check("post_ready", 32'(fmt_uplink_ready), 32'd1);
    check("post_req",   32'(fmt_req),          32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{chid: 2'd1, lcode: 3'd3, exp_len: 6'd32, gwait: 0,  base: 32'h0000_1000};
    vecs[1] = '{chid: 2'd2, lcode: 3'd0, exp_len: 6'd4,  gwait: 1,  base: 32'h0000_2000};
    vecs[2] = '{chid: 2'd2, lcode: 3'd1, exp_len: 6'd8,  gwait: 0,  base: 32'h0000_3000};
    vecs[3] = '{chid: 2'd3, lcode: 3'd2, exp_len: 6'd16, gwait: 3,  base: 32'hA5A5_0000};
    vecs[4] = '{chid: 2'd3, lcode: 3'd0, exp_len: 6'd4,  gwait: 20, base: 32'hFFFF_FFF0};
    vecs[5] = '{chid: 2'd1, lcode: 3'd7, exp_len: 6'd32, gwait: 2,  base: 32'h0000_5000};

    rst_n            = 1'b1;
    fmt_uplink_chid  = 2'd0;
    fmt_fifo0_length = 3'd0;
    fmt_fifo1_length = 3'd0;
    fmt_fifo2_length = 3'd0;
    fmt_grant        = 1'b0;
    fmt_uplink_valid = 1'b0;
    fmt_data_in      = 32'd0;
    #50;
    check_all_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick();
    check("rel_ready", 32'(fmt_uplink_ready), 32'd1);

    // chid 0 with no open packet must not start one.
    fmt_uplink_valid = 1'b1;
    fmt_uplink_chid  = 2'd0;
    fmt_data_in      = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) tick();
    fmt_uplink_valid = 1'b0;
    check("chid0_ready", 32'(fmt_uplink_ready), 32'd1);
    check("chid0_req",   32'(fmt_req),          32'd0);

    for (int v = 0; v < 6; v++) begin
      run_packet(vecs[v].chid, vecs[v].lcode, vecs[v].exp_len, vecs[v].gwait, vecs[v].base,
                 vecs[v].chid, 1000);
    end

    // Mid-packet chid change is ignored; the next packet latches the new channel.
    fmt_fifo0_length = 3'd1;
    fmt_fifo1_length = 3'd0;
    run_packet(2'd1, 3'd1, 6'd8, 0, 32'h0000_7000, 2'd2, 3);
    run_packet(2'd2, 3'd0, 6'd4, 0, 32'h0000_8000, 2'd2, 1000);

    // Async reset during DATA_SENT, then a fresh packet from word 0.
    fmt_fifo1_length = 3'd2;
    fmt_uplink_chid  = 2'd2;
    fmt_uplink_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fmt_data_in = 32'h0000_9000 + 32'(i);
      tick();
    end
    fmt_uplink_valid = 1'b0;
    fmt_uplink_chid  = 2'd0;
    check("mr_req", 32'(fmt_req), 32'd1);
    fmt_grant = 1'b1;
    tick();
    fmt_grant = 1'b0;
    tick();
    tick();
    check("mr_data_before", fmt_data, 32'h0000_9002);
    #2;
    rst_n = 1'b1;
    #1;
    check_all_zero("mr_async");
    #20;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick();
    run_packet(2'd3, 3'd0, 6'd4, 0, 32'h0000_B000, 2'd3, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mcdf_formatter.md
Name: mcdf_formatter

Overview:
- Packet formatter for the MCDF data path; sits between the upstream channel arbiter (uplink) and the downstream register/receiver interface.
- Collects one packet of 32-bit words from the uplink into an internal 64-entry cache.
- Requests the downstream bus, then emits the packet framed by start/end strobes, together with its channel id and length.

Parameters:
- DATA_WIDE, 32, data word width.
- CACHE_PTR_WIDE, 6, cache pointer/counter width.
- FMT_CACHE_DEPTH, 64, cache depth in words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous and active-high (asserted = 1) despite the name.
- fmt_uplink_chid  in  2  channel of the current uplink word: 1/2/3 = channel 0/1/2; 0 = none.
- fmt_fifo0_length  in  3  packet length code for channel 0.
- fmt_fifo1_length  in  3  packet length code for channel 1.
- fmt_fifo2_length  in  3  packet length code for channel 2.
- fmt_grant  in  1  downstream grant, answers fmt_req.
- fmt_uplink_valid  in  1  uplink word valid.
- fmt_data_in  in  DATA_WIDE  uplink data word.
- fmt_uplink_ready  out  1  formatter accepts an uplink word this cycle.
- fmt_chid  out  2  channel id of the packet being requested/sent.
- fmt_length  out  6  packet length in words.
- fmt_req  out  1  request for downstream bus.
- fmt_start  out  1  first-word strobe.
- fmt_end  out  1  last-word strobe.
- fmt_data  out  DATA_WIDE  outgoing data word.

Behaviour:
- Length decode: code 0 -> 4, 1 -> 8, 2 -> 16, 3..7 -> 32 words.
- One-hot 6-bit FSM: CHECK=000001, HAND_SHAKE=000010, SENT_START=000100, DATA_SENT=001000, SENT_END=010000, FLAG_CLR=100000.
- Reset (rst_n=1, async):
  - state=CHECK; write/read pointers and word count = 0.
  - All outputs 0; cache contents don't-care.
  - Reset mid-packet discards the packet.
- All outputs are Moore-decoded from registered state and registers.
- CHECK:
  - fmt_uplink_ready=1 while count < latched length.
  - A word is accepted when valid & ready & (chid != 0, or a packet is already open).
  - First accepted word of a packet latches chid and the decoded length, selected from the fifo length port of that channel.
  - Later words are accepted regardless of fmt_uplink_chid and are stored with the latched id; a chid change mid-packet is ignored.
  - Accepted words go to cache[wptr], then wptr++.
  - When the accepted word makes count == length: next state HAND_SHAKE; ready drops the next cycle.
  - chid = 0 with no open packet: nothing accepted.
- HAND_SHAKE:
  - fmt_req=1; fmt_chid and fmt_length show the latched values.
  - fmt_grant sampled 1 at a rising edge -> SENT_START; otherwise wait indefinitely.
- SENT_START: fmt_start=1, fmt_data=cache[0], fmt_req=0 -> DATA_SENT.
- DATA_SENT:
  - One word per cycle, cache[1]..cache[length-2].
  - After cache[length-2] -> SENT_END. Minimum length 4 guarantees at least 2 cycles here.
- SENT_END: fmt_end=1, fmt_data=cache[length-1] -> FLAG_CLR.
- fmt_chid and fmt_length are held from HAND_SHAKE through SENT_END and are 0 in CHECK and FLAG_CLR.
- fmt_data is 0 outside SENT_START..SENT_END.
- FLAG_CLR: clears pointers, count and latched chid/length; all outputs 0; -> CHECK.
- Packet latency:
  - req rises the cycle after the last word is accepted.
  - start appears one cycle after grant is sampled.
  - end appears length-1 cycles after start.
- No back-pressure during sending; the downstream side must sink one word per cycle once granted.
- Pointers never wrap within a packet: length ≤ 32 < 64.

Decomposition:
- Shared package mcdf_fmt_pkg holds:
  - DATA_WIDE, CACHE_PTR_WIDE, FMT_CACHE_DEPTH.
  - The one-hot state encodings.
  - The length-code decode function.
- One natural sub-module: fmt_cache, a 64x32 single-write/single-read register array with write enable and address, read address and combinational read.

Test Plan:
- Reset: hold rst_n=1 for 50 ns -> all outputs 0, ready=0. Release -> ready=1 in CHECK.
- chid=1, fifo0_length=3, valid=1, data incrementing from N -> after 32 accepted words:
  - ready=0 and req=1, fmt_chid=1, fmt_length=32.
  - With grant=1: start with data N, 30 middle words N+1..N+30, end with N+31, then one FLAG_CLR cycle, then ready=1.
- Lengths 0/1/2 on chid=2 and chid=3 -> fmt_length 4/8/16; exactly that many words are sent, with start on the first and end on the last.
- grant held 0 for 20 cycles in HAND_SHAKE -> req stays 1 and ready stays 0; grant=1 -> start on the next cycle.
- chid switched 1->2 mid-collection -> packet finishes with fmt_chid=1 and channel-0 length; the next packet latches chid=2.
- rst_n=1 asserted during DATA_SENT -> outputs go to 0 immediately (async); after release a fresh packet is collected from word 0.
